// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one single-port unified I/D memory between fetch and load/store.
// Grants are combinational; the owning port sees its response exactly one cycle after its grant.
module unified_mem_arbiter #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] TEXT_BASE  = 32'h0040_0000,
  parameter logic [ADDR_WIDTH-1:0] DATA_BASE  = 32'h1001_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         if_req,
  input  logic [ADDR_WIDTH-1:0]        if_addr,
  output logic                         if_gnt,
  output logic                         if_rvalid,
  output logic [DATA_WIDTH-1:0]        if_rdata,
  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [ADDR_WIDTH-1:0]        d_addr,
  input  logic [DATA_WIDTH-1:0]        d_wdata,
  output logic                         d_gnt,
  output logic                         d_rvalid,
  output logic [DATA_WIDTH-1:0]        d_rdata,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  output logic                         err
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam int HALF_WORDS = MEM_WORDS / 2;
  localparam logic [ADDR_WIDTH-1:0] REGION_BYTES = ADDR_WIDTH'(HALF_WORDS * 4);

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_IF   = 2'd1;
  localparam logic [1:0] RESP_D    = 2'd2;

  logic [1:0]            resp_q, resp_d;
  logic                  err_q, err_d;
  logic                  store_q, store_d;
  logic                  last_was_d_q, last_was_d_d;

  logic [ADDR_WIDTH-1:0] if_off_s, d_off_s;
  logic                  if_legal_s, d_legal_s;
  logic [IW-1:0]         if_idx_s, d_idx_s;

  // Wrapping subtraction makes below-base addresses land far above the region limit.
  assign if_off_s   = if_addr - TEXT_BASE;
  assign d_off_s    = d_addr - DATA_BASE;
  assign if_legal_s = (if_off_s[1:0] == 2'b00) && (if_off_s < REGION_BYTES);
  assign d_legal_s  = (d_off_s[1:0] == 2'b00) && (d_off_s < REGION_BYTES);
  assign if_idx_s   = IW'(if_off_s[ADDR_WIDTH-1:2]);
  assign d_idx_s    = IW'(HALF_WORDS) + IW'(d_off_s[ADDR_WIDTH-1:2]);

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst_n) begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
    end else if (if_req && d_req) begin
      if_gnt = last_was_d_q;
      d_gnt  = !last_was_d_q;
    end else begin
      if_gnt = if_req;
      d_gnt  = d_req;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = d_wdata;
    if (if_gnt) begin
      mem_en   = if_legal_s;
      mem_addr = if_idx_s;
    end else if (d_gnt) begin
      mem_en   = d_legal_s;
      mem_we   = d_legal_s && d_we;
      mem_addr = d_idx_s;
    end else begin
      mem_en = 1'b0;
    end
  end

  always_comb begin
    resp_d       = RESP_NONE;
    err_d        = 1'b0;
    store_d      = 1'b0;
    last_was_d_d = last_was_d_q;
    if (if_gnt) begin
      resp_d       = RESP_IF;
      err_d        = !if_legal_s;
      last_was_d_d = 1'b0;
    end else if (d_gnt) begin
      resp_d       = RESP_D;
      err_d        = !d_legal_s;
      store_d      = d_we;
      last_was_d_d = 1'b1;
    end else begin
      resp_d = RESP_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_q       <= RESP_NONE;
      err_q        <= 1'b0;
      store_q      <= 1'b0;
      last_was_d_q <= 1'b1;
    end else begin
      resp_q       <= resp_d;
      err_q        <= err_d;
      store_q      <= store_d;
      last_was_d_q <= last_was_d_d;
    end
  end

  // Responses are masked during reset so an in-flight access is dropped immediately.
  assign if_rvalid = rst_n && (resp_q == RESP_IF);
  assign d_rvalid  = rst_n && (resp_q == RESP_D);
  assign err       = (if_rvalid || d_rvalid) && err_q;
  assign if_rdata  = (if_rvalid && !err_q) ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !err_q && !store_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter: a behavioural memory map / round-robin model is
// compared against the DUT every cycle, plus directed cases with literal expectations.
module tb_unified_mem_arbiter;

  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, err;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram    [1024];
  logic [31:0] golden [1024];

  // model state
  bit          m_last_d;
  bit          p_valid, p_is_d, p_err, p_store;
  logic [31:0] p_data;
  // values computed at the sample point, committed at the next edge
  bit          n_if_gnt, n_d_gnt, n_legal, n_store;
  int          n_word;
  logic [31:0] n_data;

  always #5 clk = ~clk;

  unified_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err(err)
  );

  // single-port memory with one cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return (off % 4 == 0) && (off < 32'd2048);
  endfunction

  function automatic int word_of(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return int'(off / 4);
  endfunction

  function automatic logic [31:0] gen_addr(input logic [31:0] base);
    int r;
    logic [31:0] w;
    r = int'($urandom_range(0, 99));
    w = 32'($urandom_range(0, 511));
    if (r < 70)      return base + (w << 2);
    else if (r < 80) return base + (w << 2) + 32'($urandom_range(1, 3));
    else if (r < 90) return base + 32'd2048 + (w << 2);
    else             return base - 32'(4 * $urandom_range(1, 8));
  endfunction

  // Compare all outputs at the negedge against the model and prepare the next model state.
  task automatic sample_check();
    bit il, dl, e_en;
    int iw, dw;
    @(negedge clk);
    il = is_legal(if_addr, TEXT_BASE);
    dl = is_legal(d_addr, DATA_BASE);
    iw = word_of(if_addr, TEXT_BASE);
    dw = 512 + word_of(d_addr, DATA_BASE);
    n_if_gnt = rst_n && if_req && (!d_req || m_last_d);
    n_d_gnt  = rst_n && d_req && !n_if_gnt;
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, n_if_gnt});
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, n_d_gnt});
    e_en = (n_if_gnt && il) || (n_d_gnt && dl);
    chk("mem_en", {31'd0, mem_en}, {31'd0, e_en});
    if (e_en) begin
      chk("mem_addr", {22'd0, mem_addr}, 32'(n_if_gnt ? iw : dw));
      chk("mem_we", {31'd0, mem_we}, {31'd0, n_d_gnt && d_we});
      if (n_d_gnt && d_we) chk("mem_wdata", mem_wdata, d_wdata);
    end
    chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, rst_n && p_valid && !p_is_d});
    chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, rst_n && p_valid && p_is_d});
    chk("err", {31'd0, err}, {31'd0, rst_n && p_valid && p_err});
    chk("if_rdata", if_rdata, (rst_n && p_valid && !p_is_d && !p_err) ? p_data : 32'd0);
    chk("d_rdata", d_rdata, (rst_n && p_valid && p_is_d && !p_err && !p_store) ? p_data : 32'd0);
    n_legal = n_if_gnt ? il : dl;
    n_word  = n_if_gnt ? iw : dw;
    n_store = n_d_gnt && d_we;
    n_data  = (n_legal && !n_store) ? golden[n_word] : 32'd0;
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      p_valid  = 1'b0;
      m_last_d = 1'b1;
    end else begin
      p_valid = n_if_gnt || n_d_gnt;
      p_is_d  = n_d_gnt;
      p_err   = p_valid && !n_legal;
      p_store = n_store;
      p_data  = n_data;
      if (p_valid && n_legal && n_store) golden[n_word] = d_wdata;
      if (p_valid) m_last_d = n_d_gnt;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      golden[i] = $urandom;
      ram[i]    = golden[i];
    end
    golden[2] = 32'h00A0_0093;
    ram[2]    = 32'h00A0_0093;
    mem_rdata = 32'd0;
    m_last_d = 1'b1; p_valid = 1'b0; p_is_d = 1'b0; p_err = 1'b0; p_store = 1'b0; p_data = 32'd0;

    // reset with both ports requesting
    rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1;
    if_addr = 32'h0040_0008; d_addr = 32'h1001_0004; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 2; k++) begin
      sample_check();
      chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
      chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      advance();
    end
    rst_n = 1'b1;
    sample_check();
    chk("first_if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("fetch_addr", {22'd0, mem_addr}, 32'd2);
    advance();
    if_req = 1'b0;
    sample_check();
    chk("store_gnt", {31'd0, d_gnt}, 32'd1);
    chk("store_addr", {22'd0, mem_addr}, 32'd513);
    chk("store_we", {31'd0, mem_we}, 32'd1);
    chk("fetch_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("fetch_rdata", if_rdata, 32'h00A0_0093);
    advance();
    d_we = 1'b0;
    sample_check();
    chk("store_ack", {31'd0, d_rvalid}, 32'd1);
    chk("store_rdata", d_rdata, 32'd0);
    advance();
    d_req = 1'b0;
    sample_check();
    chk("load_rdata", d_rdata, 32'hDEAD_BEEF);
    advance();

    // contention: IF wins first since D was last
    if_req = 1'b1; d_req = 1'b1; d_addr = 32'h1001_0010;
    for (int k = 0; k < 4; k++) begin
      sample_check();
      chk("alt_if_gnt", {31'd0, if_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k > 0) chk("alt_if_rvalid", {31'd0, if_rvalid}, (k % 2 == 1) ? 32'd1 : 32'd0);
      advance();
    end
    if_req = 1'b0; d_req = 1'b0;
    sample_check();
    chk("alt_last_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    advance();

    // illegal accesses
    if_req = 1'b1; if_addr = 32'h0040_0002;
    sample_check();
    chk("mis_mem_en", {31'd0, mem_en}, 32'd0);
    advance();
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000_FFFC;
    sample_check();
    chk("mis_err", {31'd0, err}, 32'd1);
    chk("mis_rdata", if_rdata, 32'd0);
    chk("below_mem_en", {31'd0, mem_en}, 32'd0);
    advance();
    d_addr = 32'h1001_0800;
    sample_check();
    chk("below_err", {31'd0, err}, 32'd1);
    chk("below_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("above_mem_en", {31'd0, mem_en}, 32'd0);
    advance();
    d_req = 1'b0;
    sample_check();
    chk("above_err", {31'd0, err}, 32'd1);
    chk("above_rdata", d_rdata, 32'd0);
    advance();

    // reset right after a fetch grant drops the response
    if_req = 1'b1; if_addr = 32'h0040_0008;
    sample_check();
    advance();
    if_req = 1'b0; rst_n = 1'b0;
    sample_check();
    chk("midrst_rvalid", {31'd0, if_rvalid}, 32'd0);
    advance();
    rst_n = 1'b1;
    sample_check();
    chk("midrst_stale", {31'd0, if_rvalid}, 32'd0);
    advance();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      sample_check();
      advance();
      if (n_if_gnt || !if_req) begin
        if_req = ($urandom_range(0, 99) < 70);
        if_addr = gen_addr(TEXT_BASE);
      end
      if (n_d_gnt || !d_req) begin
        d_req   = ($urandom_range(0, 99) < 70);
        d_addr  = gen_addr(DATA_BASE);
        d_we    = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
      end
      rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
